video_stream_gen: RTL and testbench

- Transmit-side source for the defogging pipeline.
- Generates a raster-timed 24-bit RGB pixel stream with active-video, vsync, hsync/href and clock-enable, matching what the pipeline input stage consumes.
- Used as an on-chip stimulus source in place of a camera, and as the frame pacer for bring-up and regression.
- Supports selectable synthetic patterns and an optional pixel-enable divider.

---
 rtl/video_stream_gen.sv | 163 ++++++++++++++++
 tb/tb_video_stream_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_gen.sv
// Raster-timed RGB test-pattern source with vsync/href/active-video, pixel-slot enable and frame pulses.
// Latency: 1 clk from counter state to outputs; no backpressure, free-running once enabled, frames never truncated.
module video_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int V_ACTIVE    = 480,
    parameter int V_BLANK     = 45,
    parameter int VSYNC_LINES = 3,
    parameter int CE_DIV      = 1
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic [23:0] cmos_data,
    output logic        cmos_active_video,
    output logic        cmos_vsync,
    output logic        cmos_hsync,
    output logic        cmos_frame_ce,
    output logic        frame_start,
    output logic        frame_done
);

    localparam logic [15:0] H_LAST  = 16'(H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] V_LAST  = 16'(V_ACTIVE + V_BLANK - 1);
    localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
    localparam logic [15:0] V_BLK   = 16'(V_BLANK);
    localparam logic [15:0] V_SYNC  = 16'(VSYNC_LINES);
    localparam logic [3:0]  DIV_LAST = 4'(CE_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        run;
    logic [3:0]  div_cnt;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        ce;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_first;
    logic        frame_last;
    logic        vsync_d;
    logic        active_d;
    logic        y_bit5;
    logic [1:0]  pat_q;
    logic [1:0]  pat_cur;
    logic [23:0] rgb_q;
    logic [23:0] rgb_cur;
    logic [2:0]  bar_idx;
    logic [23:0] pix;

    assign ce          = run && (div_cnt == 4'd0);
    assign h_wrap      = (h_cnt == H_LAST);
    assign v_wrap      = (v_cnt == V_LAST);
    assign frame_first = ce && (h_cnt == 16'd0) && (v_cnt == 16'd0);
    assign frame_last  = ce && h_wrap && v_wrap;

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stopping is only honoured at a frame boundary, so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = frame_last ? IDLE : DRAIN;
            DRAIN: begin
                if (enable)          state_nxt = RUN;
                else if (frame_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run = (state != IDLE);
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n || !run) begin
            div_cnt <= 4'd0;
            h_cnt   <= 16'd0;
            v_cnt   <= 16'd0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            if (ce) begin
                if (h_wrap) begin
                    h_cnt <= 16'd0;
                    v_cnt <= v_wrap ? 16'd0 : v_cnt + 16'd1;
                end else begin
                    h_cnt <= h_cnt + 16'd1;
                end
            end
        end
    end

    assign vsync_d  = (v_cnt < V_SYNC);
    assign active_d = (v_cnt >= V_BLK) && (h_cnt < H_ACT);
    assign y_bit5   = 1'((v_cnt - V_BLK) >> 5);

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            pat_q <= 2'd0;
            rgb_q <= 24'd0;
        end else if (frame_first) begin
            pat_q <= pattern_sel;
            rgb_q <= solid_rgb;
        end
    end

    // Bypass the latch on the first slot so a frame with no vertical blanking still sees its own settings.
    assign pat_cur = frame_first ? pattern_sel : pat_q;
    assign rgb_cur = frame_first ? solid_rgb : rgb_q;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({h_cnt, 3'b000} >= 19'(k * H_ACTIVE)) bar_idx = 3'(k);
        end
    end

    // Bar colours follow the classic order, so each component is a single inverted index bit.
    always_comb begin
        pix = 24'd0;
        case (pat_cur)
            2'd0: pix = rgb_cur;
            2'd1: pix = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd2: pix = {3{h_cnt[7:0]}};
            default: pix = (h_cnt[5] ^ y_bit5) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n || !run) begin
            cmos_data         <= 24'd0;
            cmos_active_video <= 1'b0;
            cmos_vsync        <= 1'b0;
            cmos_hsync        <= 1'b0;
            cmos_frame_ce     <= 1'b0;
            frame_start       <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            cmos_frame_ce <= ce;
            frame_start   <= frame_first;
            frame_done    <= frame_last;
            if (ce) begin
                cmos_data         <= active_d ? pix : 24'd0;
                cmos_active_video <= active_d;
                cmos_hsync        <= active_d;
                cmos_vsync        <= vsync_d;
            end
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// Drives two generators (CE_DIV 1 and 3) with random enable/pattern/reset activity and
// compares every output on every clock against a slot-indexed frame model.
module tb_video_stream_gen;

    localparam int HA = 40, HB = 4, VA = 34, VB = 3, VS = 1;
    localparam int HT = HA + HB;
    localparam int FRAME = HT * (VA + VB);

    logic        pixelclk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic [23:0] o_data [2];
    logic        o_av [2];
    logic        o_vs [2];
    logic        o_hs [2];
    logic        o_ce [2];
    logic        o_fs [2];
    logic        o_fd [2];

    always #5 pixelclk = ~pixelclk;

    video_stream_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                       .VSYNC_LINES(VS), .CE_DIV(1)) dut1 (
        .pixelclk(pixelclk), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .cmos_data(o_data[0]), .cmos_active_video(o_av[0]), .cmos_vsync(o_vs[0]),
        .cmos_hsync(o_hs[0]), .cmos_frame_ce(o_ce[0]),
        .frame_start(o_fs[0]), .frame_done(o_fd[0])
    );

    video_stream_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                       .VSYNC_LINES(VS), .CE_DIV(3)) dut3 (
        .pixelclk(pixelclk), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .cmos_data(o_data[1]), .cmos_active_video(o_av[1]), .cmos_vsync(o_vs[1]),
        .cmos_hsync(o_hs[1]), .cmos_frame_ce(o_ce[1]),
        .frame_start(o_fs[1]), .frame_done(o_fd[1])
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [23:0] pix_of(input int pat, input logic [23:0] rgb, input int x, input int y);
        logic [7:0] g;
        g = 8'(x);
        case (pat)
            0: return rgb;
            1: case (x * 8 / HA)
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            2: return {g, g, g};
            default: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    // Model: a running flag, slot index within the frame and divider phase per generator.
    int          m_run [2] = '{0, 0};
    int          m_s [2];
    int          m_ph [2];
    int          m_pat [2];
    logic [23:0] m_rgb [2];
    logic [23:0] e_data [2] = '{24'd0, 24'd0};
    logic        e_av [2] = '{1'b0, 1'b0};
    logic        e_vs [2] = '{1'b0, 1'b0};
    logic        e_ce [2] = '{1'b0, 1'b0};
    logic        e_fs [2] = '{1'b0, 1'b0};
    logic        e_fd [2] = '{1'b0, 1'b0};

    task automatic clear_exp(input int d);
        e_data[d] = 24'd0; e_av[d] = 1'b0; e_vs[d] = 1'b0;
        e_ce[d] = 1'b0; e_fs[d] = 1'b0; e_fd[d] = 1'b0;
    endtask

    task automatic model_step(input int d);
        int line, x;
        bit slot;
        if (!reset_n) begin
            m_run[d] = 0;
            clear_exp(d);
        end else if (m_run[d] == 0) begin
            clear_exp(d);
            if (enable) begin
                m_run[d] = 1; m_s[d] = 0; m_ph[d] = 0;
            end
        end else begin
            slot = (m_ph[d] == 0);
            e_ce[d] = slot; e_fs[d] = 1'b0; e_fd[d] = 1'b0;
            if (slot) begin
                if (m_s[d] == 0) begin
                    m_pat[d] = int'(pattern_sel); m_rgb[d] = solid_rgb;
                end
                line = m_s[d] / HT;
                x = m_s[d] % HT;
                e_vs[d] = (line < VS);
                e_av[d] = (line >= VB) && (x < HA);
                e_fs[d] = (m_s[d] == 0);
                e_fd[d] = (m_s[d] == FRAME - 1);
                e_data[d] = e_av[d] ? pix_of(m_pat[d], m_rgb[d], x, line - VB) : 24'd0;
                if (m_s[d] == FRAME - 1 && !enable) m_run[d] = 0;
                m_s[d] = (m_s[d] + 1) % FRAME;
            end
            m_ph[d] = (m_ph[d] + 1) % div_of(d);
        end
    endtask

    int cyc = 0;
    bit brk [2] = '{1'b1, 1'b1};
    bit have_fs [2] = '{1'b0, 1'b0};
    int last_fs [2];
    int acnt [2] = '{0, 0};

    always @(posedge pixelclk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n || !enable) brk[d] = 1'b1;
            model_step(d);
        end
    end

    always @(negedge pixelclk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_data", d), 32'(o_data[d]), 32'(e_data[d]));
            check($sformatf("d%0d_active", d), 32'(o_av[d]), 32'(e_av[d]));
            check($sformatf("d%0d_hsync", d), 32'(o_hs[d]), 32'(e_av[d]));
            check($sformatf("d%0d_vsync", d), 32'(o_vs[d]), 32'(e_vs[d]));
            check($sformatf("d%0d_ce", d), 32'(o_ce[d]), 32'(e_ce[d]));
            check($sformatf("d%0d_fstart", d), 32'(o_fs[d]), 32'(e_fs[d]));
            check($sformatf("d%0d_fdone", d), 32'(o_fd[d]), 32'(e_fd[d]));
            if (o_fs[d]) begin
                if (have_fs[d] && !brk[d])
                    check($sformatf("d%0d_frame_period", d), 32'(cyc - last_fs[d]), 32'(FRAME * div_of(d)));
                have_fs[d] = 1'b1; brk[d] = 1'b0; last_fs[d] = cyc; acnt[d] = 0;
            end
            if (o_ce[d] && o_av[d]) acnt[d]++;
            if (o_fd[d]) check($sformatf("d%0d_active_count", d), 32'(acnt[d]), 32'(HA * VA));
        end
    end

    // sel: 0 = frame_start, 1 = frame_done, 2 = active_video
    task automatic wait_evt(input int sel, input int d, input int limit);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < limit && !hit; n++) begin
            @(negedge pixelclk);
            case (sel)
                0: hit = o_fs[d];
                1: hit = o_fd[d];
                default: hit = o_av[d];
            endcase
        end
        check($sformatf("wait_%0d_timeout", sel), 32'(hit), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 24'h123456;
        repeat (3) @(negedge pixelclk);
        check("reset_data", 32'(o_data[0]), 32'd0);
        check("reset_ce", 32'(o_ce[1]), 32'd0);

        // Settings latched at frame start hold even when changed mid-frame.
        reset_n = 1'b1; enable = 1'b1;
        wait_evt(0, 0, 4 * FRAME);
        repeat (FRAME / 2) @(negedge pixelclk);
        pattern_sel = 2'd3; solid_rgb = 24'hABCDEF;
        wait_evt(2, 0, FRAME);
        check("latched_solid", 32'(o_data[0]), 32'h123456);
        wait_evt(0, 0, 2 * FRAME);

        // Disable on active line 2: frame completes, then silence.
        wait_evt(0, 0, 2 * FRAME);
        repeat ((VB + 2) * HT + 5) @(negedge pixelclk);
        enable = 1'b0;
        wait_evt(1, 0, 2 * FRAME);
        repeat (10) @(negedge pixelclk);
        check("drained_active", 32'(o_av[0]), 32'd0);
        check("drained_ce", 32'(o_ce[0]), 32'd0);

        // Re-enable while draining: no gap between frames.
        enable = 1'b1; pattern_sel = 2'd1;
        wait_evt(0, 0, 2 * FRAME);
        repeat (FRAME / 2) @(negedge pixelclk);
        enable = 1'b0;
        repeat (20) @(negedge pixelclk);
        enable = 1'b1;
        wait_evt(1, 0, 2 * FRAME);
        @(negedge pixelclk);
        check("start_after_done", 32'(o_fs[0]), 32'd1);

        for (int i = 0; i < 12000; i++) begin
            @(negedge pixelclk);
            if ($urandom_range(0, 299) == 0) begin
                pattern_sel = 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
            end
            if ($urandom_range(0, 799) == 0) enable = ~enable;
        end

        // Mid-frame reset aborts at once; restart takes IDLE then RUN.
        enable = 1'b1; pattern_sel = 2'd2;
        repeat (FRAME + HT / 2) @(negedge pixelclk);
        reset_n = 1'b0;
        @(negedge pixelclk);
        check("rst_mid_data", 32'(o_data[0]), 32'd0);
        check("rst_mid_ce", 32'(o_ce[0]), 32'd0);
        check("rst_mid_ce3", 32'(o_ce[1]), 32'd0);
        @(negedge pixelclk);
        reset_n = 1'b1;
        @(negedge pixelclk);
        check("rst_rel_idle", 32'(o_fs[0]), 32'd0);
        @(negedge pixelclk);
        check("rst_rel_fstart", 32'(o_fs[0]), 32'd1);
        check("rst_rel_vsync", 32'(o_vs[0]), 32'd1);

        repeat (2 * FRAME) @(negedge pixelclk);
        enable = 1'b0;
        repeat (3 * FRAME + 20) @(negedge pixelclk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("final_data_%0d", d), 32'(o_data[d]), 32'd0);
            check($sformatf("final_ce_%0d", d), 32'(o_ce[d]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
